seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Multiplexed 4-digit 7-segment display scanner. Each rising edge
//            of scan_clk (synchronized into clk_in) advances to the next
//            digit. Every digit is held dark for BLANK_CYCLES cycles before
//            its anode is enabled, so a digit change never ghosts.
//            Display data is captured once per frame (at digit 0) so that a
//            frame always shows a consistent value.
// Ports    : clk_in      - system clock, rising edge
//            rst         - synchronous active-high reset
//            scan_clk    - divided scan clock, sampled as data
//            digits      - four hex nibbles, [3:0] = digit 0 (rightmost)
//            blank_mask  - bit i forces digit i dark
//            dp_mask     - bit i lights the decimal point of digit i
//            an          - active-low anode enables
//            seg         - active-low cathodes, seg[0]=a .. seg[6]=g
//            dp          - active-low decimal point
//            frame_start - one-cycle pulse as a new frame begins
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic [15:0] digits,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    // Counter reload value: the counter runs BLANK_CYCLES-1 down to 0, which
    // keeps the FSM in BLANK for exactly BLANK_CYCLES cycles.
    localparam logic [7:0] c_CNT_LOAD = 8'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // scan_clk synchronizer and rising-edge detect. Reset to 1 so a
    // scan_clk that is already high at reset release is not seen as an edge.
    // ------------------------------------------------------------------
    logic r_s1, r_s2, r_s3;
    logic w_scan_tick;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= scan_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_scan_tick = r_s2 & ~r_s3;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    state_t      r_state, w_state_next;
    logic [1:0]  r_idx,   w_idx_next;
    logic [7:0]  r_cnt,   w_cnt_next;
    logic        w_latch;

    logic [15:0] r_sh_digits;
    logic [3:0]  r_sh_blank;
    logic [3:0]  r_sh_dp;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_scan_tick) begin
                    w_idx_next   = 2'd0;
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = ST_BLANK;
                    w_latch      = 1'b1;
                end
            end
            ST_BLANK: begin
                // Ticks arriving here are intentionally ignored.
                if (r_cnt == 8'd0) begin
                    w_state_next = ST_DRIVE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            ST_DRIVE: begin
                if (w_scan_tick) begin
                    w_idx_next   = r_idx + 2'd1;
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = ST_BLANK;
                    // Wrapping back to digit 0 starts a new frame.
                    w_latch      = (r_idx == 2'd3);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = 2'd0;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 8'd0;
            r_sh_digits <= 16'h0000;
            r_sh_blank  <= 4'h0;
            r_sh_dp     <= 4'h0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_sh_digits <= digits;
                r_sh_blank  <= blank_mask;
                r_sh_dp     <= dp_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode, driven only from the shadow copies
    // ------------------------------------------------------------------
    logic [3:0] w_nibble;
    logic [6:0] w_font;      // active-high gfedcba
    logic       w_lit;
    logic [3:0] w_an_next;
    logic [6:0] w_seg_next;
    logic       w_dp_next;
    logic       w_fs_next;

    assign w_nibble = r_sh_digits[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_font = 7'h00;
        case (w_nibble)
            4'h0: w_font = 7'h3F;
            4'h1: w_font = 7'h06;
            4'h2: w_font = 7'h5B;
            4'h3: w_font = 7'h4F;
            4'h4: w_font = 7'h66;
            4'h5: w_font = 7'h6D;
            4'h6: w_font = 7'h7D;
            4'h7: w_font = 7'h07;
            4'h8: w_font = 7'h7F;
            4'h9: w_font = 7'h6F;
            4'hA: w_font = 7'h77;
            4'hB: w_font = 7'h7C;
            4'hC: w_font = 7'h39;
            4'hD: w_font = 7'h5E;
            4'hE: w_font = 7'h79;
            4'hF: w_font = 7'h71;
            default: w_font = 7'h00;
        endcase
    end

    always_comb begin
        w_lit      = (r_state == ST_DRIVE) && !r_sh_blank[r_idx];
        w_an_next  = 4'hF;
        w_seg_next = 7'h7F;
        w_dp_next  = 1'b1;
        if (w_lit) begin
            w_an_next  = ~(4'b0001 << r_idx);
            w_seg_next = ~w_font;
            w_dp_next  = ~r_sh_dp[r_idx];
        end
        // First cycle of the digit-0 blank period marks the frame start.
        w_fs_next = (r_state == ST_BLANK) && (r_idx == 2'd0) && (r_cnt == c_CNT_LOAD);
    end

    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;
    logic       r_frame_start;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_an          <= 4'hF;
            r_seg         <= 7'h7F;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_next;
            r_seg         <= w_seg_next;
            r_dp          <= w_dp_next;
            r_frame_start <= w_fs_next;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
